// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Decides each cycle whether the ID instruction may advance into ID/EXE
//   or must be held. It tracks the instructions in EXE and MEM with a
//   private two-slot scoreboard and counts stall and branch-flush cycles.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   id_*                decoded fields of the instruction currently in ID
//   exe_b_taken         branch resolved taken in EXE this cycle
//   mem_freeze          data memory busy; the whole pipeline holds
//   fwd_en              forwarding unit active
//   hazard              data hazard on the ID instruction (combinational)
//   freeze_if           hold PC and IF/ID
//   flush_if            squash IF/ID
//   flush_id            load a bubble into ID/EXE
//   stall_cnt           saturating count of hazard-stalled cycles
//   flush_cnt           saturating count of branch-flush cycles
module hazard_stall_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic             id_use_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src2,
  input  logic [3:0]       id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             exe_b_taken,
  input  logic             mem_freeze,
  input  logic             fwd_en,
  output logic             hazard,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             flush_id,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       wb_en;
    logic       mem_r_en;
  } slot_t;

  slot_t slot_e, slot_m;

  // A slot matches a source only if it will write that register and the
  // ID instruction really reads it.
  function automatic logic src_match(slot_t s, logic [3:0] src, logic use_src);
    return s.valid & s.wb_en & use_src & (s.dest == src);
  endfunction

  logic hit_e, hit_m, raw;

  assign hit_e = src_match(slot_e, id_src1, id_use_src1) |
                 src_match(slot_e, id_src2, id_use_src2);
  assign hit_m = src_match(slot_m, id_src1, id_use_src1) |
                 src_match(slot_m, id_src2, id_use_src2);

  // With forwarding only a load still in EXE cannot supply its result in
  // time; without it any in-flight writer blocks. WB writers never block
  // because the register file writes before it reads.
  assign raw = fwd_en ? (slot_e.mem_r_en & hit_e) : (hit_e | hit_m);

  // A taken branch squashes the ID instruction, so it cannot stall.
  assign hazard    = id_valid & ~exe_b_taken & raw;
  assign freeze_if = hazard | mem_freeze;
  assign flush_if  = exe_b_taken & ~mem_freeze;
  assign flush_id  = (hazard | exe_b_taken) & ~mem_freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_e <= '0;
      slot_m <= '0;
    end else if (!mem_freeze) begin
      slot_e.valid    <= id_valid & ~hazard & ~exe_b_taken;
      slot_e.dest     <= id_dest;
      slot_e.wb_en    <= id_wb_en;
      slot_e.mem_r_en <= id_mem_r_en;
      slot_m          <= slot_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_freeze) begin
      if (hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (exe_b_taken && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic        clk, rst;
  logic        id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_r_en;
  logic [3:0]  id_src1, id_src2, id_dest;
  logic        exe_b_taken, mem_freeze, fwd_en;
  logic        hazard, freeze_if, flush_if, flush_id;
  logic [31:0] stall_cnt, flush_cnt;
  logic        hazard4, freeze_if4, flush_if4, flush_id4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_assert = 0;
  int n_fail   = 0;

  hazard_stall_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
    .id_use_src1(id_use_src1), .id_src2(id_src2), .id_use_src2(id_use_src2),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .exe_b_taken(exe_b_taken), .mem_freeze(mem_freeze), .fwd_en(fwd_en),
    .hazard(hazard), .freeze_if(freeze_if), .flush_if(flush_if),
    .flush_id(flush_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance driven by the same stimulus for saturation.
  hazard_stall_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
    .id_use_src1(id_use_src1), .id_src2(id_src2), .id_use_src2(id_use_src2),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .exe_b_taken(exe_b_taken), .mem_freeze(mem_freeze), .fwd_en(fwd_en),
    .hazard(hazard4), .freeze_if(freeze_if4), .flush_if(flush_if4),
    .flush_id(flush_id4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: history of issued instructions ----
  // hist_*[0] is the instruction issued most recently (now in EXE),
  // hist_*[1] the one issued before it (now in MEM). Bubbles have v=0.
  logic       hist_v[2], hist_w[2], hist_l[2];
  logic [3:0] hist_d[2];
  int         mdl_stall, mdl_flush;

  function automatic void mdl_clear();
    for (int a = 0; a < 2; a++) begin
      hist_v[a] = 0; hist_w[a] = 0; hist_l[a] = 0; hist_d[a] = 0;
    end
    mdl_stall = 0;
    mdl_flush = 0;
  endfunction

  function automatic logic mdl_hazard();
    logic r;
    r = 0;
    for (int a = 0; a < 2; a++) begin
      if (hist_v[a] && hist_w[a] &&
          ((id_use_src1 && id_src1 == hist_d[a]) ||
           (id_use_src2 && id_src2 == hist_d[a]))) begin
        if (!fwd_en) r = 1;
        else if (a == 0 && hist_l[a]) r = 1;
      end
    end
    return id_valid && !exe_b_taken && r;
  endfunction

  function automatic void mdl_clock(input logic hz);
    if (mem_freeze) return;
    hist_v[1] = hist_v[0]; hist_w[1] = hist_w[0];
    hist_l[1] = hist_l[0]; hist_d[1] = hist_d[0];
    hist_v[0] = id_valid && !hz && !exe_b_taken;
    hist_w[0] = id_wb_en; hist_l[0] = id_mem_r_en; hist_d[0] = id_dest;
    if (hz) mdl_stall++;
    if (exe_b_taken) mdl_flush++;
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                        input logic [3:0] s2, input logic u2,
                        input logic [3:0] d, input logic w, input logic l);
    id_valid = v; id_src1 = s1; id_use_src1 = u1; id_src2 = s2;
    id_use_src2 = u2; id_dest = d; id_wb_en = w; id_mem_r_en = l;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    exe_b_taken = 0;
    mem_freeze  = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    mdl_clear();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    fwd_en = 0;
    rst = 1;
    #3;
    tick();
    rst = 0;
    #1;
    n_assert++;
    if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %b want 0", hazard); end
    n_assert++;
    if (flush_id !== 1'b0) begin n_fail++; $display("FAIL reset_flush_id got %b want 0", flush_id); end
    n_assert++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    n_assert++;
    if (flush_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_flush_cnt got %0d want 0", flush_cnt); end
    tick();
  endtask

  task automatic test_alu_stall();
    do_reset();
    fwd_en = 0;
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd1, 1, 0);     // ADD R1
    #1;
    n_assert++;
    if (hazard !== 1'b0) begin n_fail++; $display("FAIL alu_producer_hazard got %b want 0", hazard); end
    tick();
    set_id(1, 4'd1, 1, 4'd7, 0, 4'd2, 1, 0);     // SUB R2, R1
    for (int k = 0; k < 2; k++) begin
      #1;
      n_assert++;
      if (hazard !== 1'b1 || freeze_if !== 1'b1 || flush_id !== 1'b1) begin
        n_fail++;
        $display("FAIL alu_stall_cycle%0d got hz=%b fz=%b fid=%b want 1 1 1", k, hazard, freeze_if, flush_id);
      end
      tick();
    end
    #1;
    n_assert++;
    if (hazard !== 1'b0) begin n_fail++; $display("FAIL alu_issue_hazard got %b want 0", hazard); end
    n_assert++;
    if (stall_cnt !== 32'd2) begin n_fail++; $display("FAIL alu_stall_cnt got %0d want 2", stall_cnt); end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    fwd_en = 1;
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 1);     // LDR R2
    tick();
    set_id(1, 4'd5, 1, 4'd2, 1, 4'd6, 1, 0);     // ADD R6, R5, R2
    #1;
    n_assert++;
    if (hazard !== 1'b1) begin n_fail++; $display("FAIL load_use_hazard got %b want 1", hazard); end
    tick();
    n_assert++;
    if (hazard !== 1'b0) begin n_fail++; $display("FAIL load_use_after_bubble got %b want 0", hazard); end
    n_assert++;
    if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL load_use_stall_cnt got %0d want 1", stall_cnt); end
    tick();
    do_reset();
    fwd_en = 1;
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0);     // ADD R2
    tick();
    set_id(1, 4'd5, 1, 4'd2, 1, 4'd6, 1, 0);
    #1;
    n_assert++;
    if (hazard !== 1'b0) begin n_fail++; $display("FAIL alu_fwd_hazard got %b want 0", hazard); end
    tick();
    n_assert++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL alu_fwd_stall_cnt got %0d want 0", stall_cnt); end
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    fwd_en = 0;
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd1, 1, 0);     // ADD R1
    tick();
    set_id(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 0);     // dependent, writes R5
    exe_b_taken = 1;
    #1;
    n_assert++;
    if (hazard !== 1'b0 || flush_if !== 1'b1 || flush_id !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_outputs got hz=%b fif=%b fid=%b want 0 1 1", hazard, flush_if, flush_id);
    end
    tick();
    exe_b_taken = 0;
    n_assert++;
    if (flush_cnt !== 32'd1) begin n_fail++; $display("FAIL branch_flush_cnt got %0d want 1", flush_cnt); end
    // The squashed instruction must not occupy EXE: a reader of R5 is clear.
    set_id(1, 4'd5, 1, 4'd0, 0, 4'd6, 1, 0);
    #1;
    n_assert++;
    if (hazard !== 1'b0) begin n_fail++; $display("FAIL branch_squashed_slot got %b want 0", hazard); end
    tick();
    idle();
  endtask

  task automatic test_freeze();
    do_reset();
    fwd_en = 0;
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0);     // ADD R3
    tick();
    set_id(1, 4'd0, 0, 4'd3, 1, 4'd4, 1, 0);     // reads R3 via src2
    tick();                                      // first stall cycle counted
    mem_freeze = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_assert++;
      if (hazard !== 1'b1 || freeze_if !== 1'b1 || flush_id !== 1'b0 || flush_if !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_outputs%0d got hz=%b fz=%b fid=%b fif=%b want 1 1 0 0", k, hazard, freeze_if, flush_id, flush_if);
      end
      tick();
      n_assert++;
      if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL freeze_stall_hold%0d got %0d want 1", k, stall_cnt); end
    end
    mem_freeze = 0;
    #1;
    n_assert++;
    if (hazard !== 1'b1) begin n_fail++; $display("FAIL freeze_resume_hazard got %b want 1", hazard); end
    tick();
    n_assert++;
    if (hazard !== 1'b0 || stall_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL freeze_resume_done got hz=%b cnt=%0d want 0 2", hazard, stall_cnt);
    end
    tick();
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    fwd_en = 0;
    set_id(1, 4'd0, 0, 4'd0, 0, 4'd8, 1, 0);
    tick();
    set_id(1, 4'd8, 1, 4'd0, 0, 4'd9, 1, 0);
    #2;
    n_assert++;
    if (hazard !== 1'b1) begin n_fail++; $display("FAIL async_pre_hazard got %b want 1", hazard); end
    rst = 1;
    #1;
    n_assert++;
    if (hazard !== 1'b0) begin n_fail++; $display("FAIL async_rst_hazard got %b want 0", hazard); end
    tick();
    rst = 0;
    idle();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    fwd_en = 0;
    // Self-dependent instruction held in ID: stalls 2 of every 3 cycles.
    set_id(1, 4'd1, 1, 4'd0, 0, 4'd1, 1, 0);
    for (int k = 0; k < 30; k++) tick();
    n_assert++;
    if (stall_cnt !== 32'd20) begin n_fail++; $display("FAIL sat_wide_cnt got %0d want 20", stall_cnt); end
    n_assert++;
    if (stall_cnt4 !== 4'hF) begin n_fail++; $display("FAIL sat_narrow_cnt got %0d want 15", stall_cnt4); end
    idle();
  endtask

  task automatic test_random();
    logic hz;
    do_reset();
    fwd_en = 0;
    for (int c = 0; c < 400; c++) begin
      set_id($urandom_range(0, 9) < 8, 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
      exe_b_taken = $urandom_range(0, 9) == 0;
      mem_freeze  = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 19) == 0) fwd_en = ~fwd_en;
      #1;
      hz = mdl_hazard();
      n_assert++;
      if (hazard !== hz || freeze_if !== (hz | mem_freeze) ||
          flush_if !== (exe_b_taken & ~mem_freeze) ||
          flush_id !== ((hz | exe_b_taken) & ~mem_freeze)) begin
        n_fail++;
        $display("FAIL rand_comb c=%0d got hz=%b fz=%b fif=%b fid=%b want hz=%b", c, hazard, freeze_if, flush_if, flush_id, hz);
      end
      n_assert++;
      if (stall_cnt !== 32'(mdl_stall) || flush_cnt !== 32'(mdl_flush)) begin
        n_fail++;
        $display("FAIL rand_cnt c=%0d got %0d/%0d want %0d/%0d", c, stall_cnt, flush_cnt, mdl_stall, mdl_flush);
      end
      n_assert++;
      if (stall_cnt4 !== 4'(sat15(mdl_stall)) || flush_cnt4 !== 4'(sat15(mdl_flush))) begin
        n_fail++;
        $display("FAIL rand_cnt4 c=%0d got %0d/%0d want %0d/%0d", c, stall_cnt4, flush_cnt4, sat15(mdl_stall), sat15(mdl_flush));
      end
      @(posedge clk);
      mdl_clock(hz);
      #1;
    end
    idle();
  endtask

  initial begin
    rst = 1;
    fwd_en = 0;
    idle();
    mdl_clear();
    test_reset();
    test_alu_stall();
    test_load_use();
    test_branch();
    test_freeze();
    test_async_reset();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
